// File: rtl/vga_display_if.sv
// ---------------------------------------------------------------------------
// vga_display_if
// Bundles the pixel-source side and the panel side of the display timing
// controller into one interface.
//
// Signals:
//   red_in/green_in/blue_in  8 each  colour from the pattern source, meaningful
//                                    only while pixel_req is high
//   pixel_req                1       current raster position is visible
//   pixel_x                  11      horizontal counter
//   pixel_y                  10      vertical counter
//   frame_start              1       raster is at (0,0)
//   vga_r/vga_g/vga_b        8 each  registered panel colour
//   hsync/vsync              1 each  registered syncs
//   de                       1       registered data enable
//
// Modports:
//   master - the timing controller (drives raster info and panel pins)
//   slave  - the pixel source / panel side
// ---------------------------------------------------------------------------
interface vga_display_if;
    logic [7:0]  red_in;
    logic [7:0]  green_in;
    logic [7:0]  blue_in;
    logic        pixel_req;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        de;

    modport master (
        input  red_in, green_in, blue_in,
        output pixel_req, pixel_x, pixel_y, frame_start,
        output vga_r, vga_g, vga_b, hsync, vsync, de
    );

    modport slave (
        output red_in, green_in, blue_in,
        input  pixel_req, pixel_x, pixel_y, frame_start,
        input  vga_r, vga_g, vga_b, hsync, vsync, de
    );
endinterface

// File: rtl/vga_display_ctrl.sv
// ---------------------------------------------------------------------------
// vga_display_ctrl
// Display-side raster timing controller. Owns the horizontal/vertical
// counters, tells the pixel source which pixel it wants, and registers
// sync, data enable and colour so all panel outputs share one clock of
// latency relative to the counter position that produced them.
//
// Ports:
//   vga_clk  in   pixel clock, all logic on its rising edge
//   arst_n   in   asynchronous active-low reset
//   vid      vga_display_if.master
//              in : red_in, green_in, blue_in
//              out: pixel_req, pixel_x, pixel_y, frame_start (combinational)
//                   vga_r, vga_g, vga_b, hsync, vsync, de (registered)
// ---------------------------------------------------------------------------
module vga_display_ctrl #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic          vga_clk,
    input  logic          arst_n,
    vga_display_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are fixed at 11/10 bits, so the raster must fit inside them.
    if (H_TOTAL > 2048) begin : g_h_too_big
        $fatal(1, "vga_display_ctrl: H_TOTAL exceeds 11-bit counter");
    end
    if (V_TOTAL > 1024) begin : g_v_too_big
        $fatal(1, "vga_display_ctrl: V_TOTAL exceeds 10-bit counter");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // Window bounds are one bit wider than the counters so an end bound of
    // exactly 2048/1024 cannot wrap to zero.
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        active;
    logic        hs_raw;
    logic        vs_raw;

    // Raster counters: h runs every clock, v advances on the h wrap, and both
    // return to zero together at the end of the last line.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Position decode; vsync spans whole lines so it only looks at v_cnt.
    always_comb begin
        active = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
        hs_raw = ({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END);
        vs_raw = ({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END);
    end

    assign vid.pixel_req   = active;
    assign vid.pixel_x     = h_cnt;
    assign vid.pixel_y     = v_cnt;
    assign vid.frame_start = (h_cnt == 11'd0) && (v_cnt == 10'd0);

    // Output register stage. Colour is forced to zero outside the active
    // window so whatever the source drives during blanking never reaches
    // the panel.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            vid.de    <= 1'b0;
            vid.hsync <= ~HS_POL;
            vid.vsync <= ~VS_POL;
            vid.vga_r <= '0;
            vid.vga_g <= '0;
            vid.vga_b <= '0;
        end else begin
            vid.de    <= active;
            vid.hsync <= hs_raw ? HS_POL : ~HS_POL;
            vid.vsync <= vs_raw ? VS_POL : ~VS_POL;
            vid.vga_r <= active ? vid.red_in   : 8'h00;
            vid.vga_g <= active ? vid.green_in : 8'h00;
            vid.vga_b <= active ? vid.blue_in  : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_display_ctrl
// Directed bench for vga_display_ctrl. One instance uses the full 800x480
// timing for line-level behaviour; a second, tiny-raster instance
// (16 clocks x 9 lines) makes whole-frame behaviour cheap to observe.
// Small raster: H 8/2/3/3 -> hsync h in [10,13); V 4/1/2/2 -> vsync v in [5,7).
// ---------------------------------------------------------------------------
module tb_vga_display_ctrl;

    logic vga_clk = 1'b0;
    logic arst_n;

    int compared   = 0;
    int mismatched = 0;

    vga_display_if vid ();
    vga_display_if vid_s ();

    vga_display_ctrl dut (
        .vga_clk (vga_clk),
        .arst_n  (arst_n),
        .vid     (vid.master)
    );

    vga_display_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1'b0), .VS_POL (1'b0)
    ) dut_s (
        .vga_clk (vga_clk),
        .arst_n  (arst_n),
        .vid     (vid_s.master)
    );

    // 10 ns pixel clock; all sampling happens on the falling edge.
    always #5 vga_clk = ~vga_clk;

    // One comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the full-timing instance's colour inputs.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b);
        vid.red_in   = r;
        vid.green_in = g;
        vid.blue_in  = b;
    endtask

    initial begin
        int de_cnt;
        int hs_low;
        int hs_first;
        int hs_runs;
        int vs_low;
        int x_seen;
        int bad_blank;
        int bad_active;
        int fs_period;
        int max_x;
        int max_y;
        int guard;
        logic prev_hs;

        arst_n = 1'b0;
        applyStimulus(8'hFF, 8'h00, 8'h00);
        vid_s.red_in   = 8'hAA;
        vid_s.green_in = 8'hBB;
        vid_s.blue_in  = 8'hCC;

        // ---------------- reset state ----------------
        repeat (3) @(negedge vga_clk);
        checkOutput("rst_de",     32'(vid.de), 32'd0);
        checkOutput("rst_vga_r",  32'(vid.vga_r), 32'd0);
        checkOutput("rst_hsync",  32'(vid.hsync), 32'd1);
        checkOutput("rst_vsync",  32'(vid.vsync), 32'd1);
        checkOutput("rst_px",     32'(vid.pixel_x), 32'd0);
        checkOutput("rst_py",     32'(vid.pixel_y), 32'd0);
        checkOutput("rst_req",    32'(vid.pixel_req), 32'd1);
        checkOutput("rst_fs",     32'(vid.frame_start), 32'd1);
        arst_n = 1'b1;

        // ---------------- line 0: de/hsync shape ----------------
        de_cnt = 0; hs_low = 0; hs_first = -1; hs_runs = 0; vs_low = 0;
        prev_hs = 1'b1;
        for (int k = 1; k <= 1056; k++) begin
            @(negedge vga_clk);
            if (k == 1) begin
                checkOutput("c1_de",    32'(vid.de), 32'd1);
                checkOutput("c1_vga_r", 32'(vid.vga_r), 32'hFF);
                checkOutput("c1_px",    32'(vid.pixel_x), 32'd1);
            end
            if (k == 801) begin
                checkOutput("c801_de",    32'(vid.de), 32'd0);
                checkOutput("c801_vga_r", 32'(vid.vga_r), 32'd0);
            end
            if (vid.de === 1'b1) de_cnt++;
            if (vid.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
                if (prev_hs === 1'b1) hs_runs++;
            end
            if (vid.vsync === 1'b0) vs_low++;
            prev_hs = vid.hsync;
        end
        checkOutput("line_de_count",   32'(de_cnt), 32'd800);
        checkOutput("line_hs_low",     32'(hs_low), 32'd128);
        checkOutput("line_hs_first",   32'(hs_first), 32'd841);
        checkOutput("line_hs_runs",    32'(hs_runs), 32'd1);
        checkOutput("line0_vs_low",    32'(vs_low), 32'd0);
        checkOutput("line_wrap_px",    32'(vid.pixel_x), 32'd0);
        checkOutput("line_wrap_py",    32'(vid.pixel_y), 32'd1);

        // ---------------- line 1: X during blanking ----------------
        x_seen = 0; bad_blank = 0; bad_active = 0; de_cnt = 0;
        for (int k = 0; k < 1056; k++) begin
            if (vid.pixel_req === 1'b1) applyStimulus(8'h12, 8'h34, 8'h56);
            else                        applyStimulus('x, 'x, 'x);
            @(negedge vga_clk);
            if ($isunknown({vid.vga_r, vid.vga_g, vid.vga_b, vid.de})) x_seen++;
            if (vid.de === 1'b0 && {vid.vga_r, vid.vga_g, vid.vga_b} !== 24'h0)
                bad_blank++;
            if (vid.de === 1'b1) begin
                de_cnt++;
                if ({vid.vga_r, vid.vga_g, vid.vga_b} !== 24'h123456) bad_active++;
            end
        end
        checkOutput("x_outputs_unknown", 32'(x_seen), 32'd0);
        checkOutput("x_blank_nonzero",   32'(bad_blank), 32'd0);
        checkOutput("x_active_colour",   32'(bad_active), 32'd0);
        checkOutput("x_de_count",        32'(de_cnt), 32'd800);
        applyStimulus(8'hFF, 8'h00, 8'h00);

        // ---------------- small raster: full frame ----------------
        guard = 0;
        while (vid_s.frame_start !== 1'b1 && guard < 200) begin
            @(negedge vga_clk);
            guard++;
        end
        checkOutput("s_wait_fs", 32'(vid_s.frame_start), 32'd1);
        de_cnt = 0; vs_low = 0; hs_first = -1; fs_period = -1; max_x = 0; max_y = 0;
        for (int n = 1; n <= 144; n++) begin
            @(negedge vga_clk);
            if (vid_s.de === 1'b1) de_cnt++;
            if (vid_s.vsync === 1'b0) begin
                vs_low++;
                if (hs_first < 0) hs_first = n;
            end
            if (vid_s.frame_start === 1'b1 && fs_period < 0) fs_period = n;
            if (int'(vid_s.pixel_x) > max_x) max_x = int'(vid_s.pixel_x);
            if (int'(vid_s.pixel_y) > max_y) max_y = int'(vid_s.pixel_y);
            if (n == 143) begin
                checkOutput("s_last_px", 32'(vid_s.pixel_x), 32'd15);
                checkOutput("s_last_py", 32'(vid_s.pixel_y), 32'd8);
            end
            if (n == 144) begin
                checkOutput("s_wrap_px", 32'(vid_s.pixel_x), 32'd0);
                checkOutput("s_wrap_py", 32'(vid_s.pixel_y), 32'd0);
                checkOutput("s_wrap_fs", 32'(vid_s.frame_start), 32'd1);
            end
        end
        checkOutput("s_de_count",  32'(de_cnt), 32'd32);
        checkOutput("s_vs_low",    32'(vs_low), 32'd32);
        checkOutput("s_vs_first",  32'(hs_first), 32'd81);
        checkOutput("s_fs_period", 32'(fs_period), 32'd144);
        checkOutput("s_max_x",     32'(max_x), 32'd15);
        checkOutput("s_max_y",     32'(max_y), 32'd8);

        // ---------------- asynchronous reset mid-line at h=500 ----------------
        guard = 0;
        while (vid.pixel_x !== 11'd500 && guard < 1100) begin
            @(negedge vga_clk);
            guard++;
        end
        checkOutput("m_wait_px", 32'(vid.pixel_x), 32'd500);
        checkOutput("m_pre_de",  32'(vid.de), 32'd1);
        arst_n = 1'b0;
        #1;
        checkOutput("m_async_de",    32'(vid.de), 32'd0);
        checkOutput("m_async_vga_r", 32'(vid.vga_r), 32'd0);
        checkOutput("m_async_px",    32'(vid.pixel_x), 32'd0);
        checkOutput("m_async_fs",    32'(vid.frame_start), 32'd1);
        repeat (3) @(negedge vga_clk);
        checkOutput("m_hold_de", 32'(vid.de), 32'd0);
        checkOutput("m_hold_px", 32'(vid.pixel_x), 32'd0);
        arst_n = 1'b1;
        checkOutput("m_rel_px", 32'(vid.pixel_x), 32'd0);
        checkOutput("m_rel_py", 32'(vid.pixel_y), 32'd0);
        checkOutput("m_rel_fs", 32'(vid.frame_start), 32'd1);
        @(negedge vga_clk);
        checkOutput("m_c1_de",    32'(vid.de), 32'd1);
        checkOutput("m_c1_vga_r", 32'(vid.vga_r), 32'hFF);
        checkOutput("m_c1_px",    32'(vid.pixel_x), 32'd1);

        // ---------------- reset while hsync is asserted ----------------
        guard = 0;
        while (vid.pixel_x !== 11'd900 && guard < 1100) begin
            @(negedge vga_clk);
            guard++;
        end
        checkOutput("h_wait_px",  32'(vid.pixel_x), 32'd900);
        checkOutput("h_pre_hs",   32'(vid.hsync), 32'd0);
        arst_n = 1'b0;
        #1;
        checkOutput("h_async_hs", 32'(vid.hsync), 32'd1);
        @(negedge vga_clk);
        arst_n = 1'b1;
        @(negedge vga_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_display_ctrl.md
# vga_display_ctrl

Display-side timing controller that consumes the per-pixel RGB stream produced by the pattern generators and drives the VGA/LCD panel interface. It owns the horizontal/vertical raster counters, tells the pixel source which pixel to produce, and emits registered sync, data-enable and RGB aligned to one clock of latency. It sits between the pattern source (`image`/`image2` class blocks) and the board's video output pins, all on `vga_clk`.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BP, 88, horizontal back porch (clocks); H_TOTAL = sum = 1056
- V_ACTIVE, 480, visible lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 525
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- vga_clk  in  1  pixel clock; all logic on rising edge
- arst_n  in  1  asynchronous active-low reset, deassertion synchronous to vga_clk externally
- red_in, green_in, blue_in  in  8 each  pixel colour from source, valid in the cycle pixel_req=1
- pixel_req  out  1  current counter position is active (combinational from counters)
- pixel_x  out  11  current h counter (0..H_TOTAL-1)
- pixel_y  out  10  current v counter (0..V_TOTAL-1)
- frame_start  out  1  high for the single cycle h=0, v=0
- vga_r, vga_g, vga_b  out  8 each  registered output colour
- hsync, vsync  out  1 each  registered sync
- de  out  1  registered data enable

## Operation
- h_cnt increments every cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap returns to 0 (frame wrap). Both wrap on the same edge at (1055, 524) -> (0, 0).
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE); pixel_req = active.
- hs_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [840, 968).
- vs_raw = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [493, 496), for full lines (all h values).
- Output register stage: de <= active; hsync <= hs_raw ? HS_POL : ~HS_POL; vsync likewise with VS_POL; vga_rgb <= active ? rgb_in : 0.
- Inputs ignored (not propagated) whenever active=0; X on inputs during blanking must not reach outputs.
- Counter widths: h 11 bits, v 10 bits; parameter sums must fit (elaboration-time check, fatal if H_TOTAL > 2048 or V_TOTAL > 1024).
- No free-running state beyond the two counters and the output register; no FSM gaps (every counter value reachable).

## Timing
- Reset (arst_n=0, asynchronous): h_cnt=0, v_cnt=0, de=0, vga_r/g/b=0, hsync=~HS_POL (1), vsync=~VS_POL (1). Combinational outputs then read pixel_x=0, pixel_y=0, pixel_req=1, frame_start=1.
- First rising edge after release: output register captures position (0,0): de=1, vga_rgb=rgb_in; counter moves to (1,0).
- Latency: colour presented at counter position N appears on vga_r/g/b exactly one cycle later, aligned with de/hsync/vsync for that position.
- hsync asserted 128 clocks per line starting the cycle after h_cnt=840; vsync asserted 3x1056 = 3168 clocks per frame.
- Frame period = 1056 x 525 = 554400 clocks; active clocks per frame = 384000.
- Reset asserted mid-frame: outputs go to reset values immediately (no clock); counters restart at (0,0) on release.

## Test plan
- Reset release, rgb_in=FF/00/00: cycle 1 after release de=1, vga_r=FF; cycle 801 de=0, vga_r=00.
- Count one line: hsync low for exactly 128 consecutive clocks, first low sample at output cycle for h=840; de high exactly 800 clocks per active line.
- Full frame: frame_start pulses every 554400 clocks; vsync low 3168 clocks starting at line 493; de high 384000 clocks per frame.
- Drive rgb_in = X during blanking, constant 12/34/56 during active: outputs never X, exactly 0 when de=0, 12/34/56 when de=1.
- Assert arst_n low at h=500, v=200 for 3 cycles: outputs hold reset values asynchronously; after release pixel_x/pixel_y restart at 0/0 and frame_start=1.
- Wrap check: at (1055,524) next cycle shows pixel_x=0, pixel_y=0, frame_start=1; no extra line or column.
